bno085_report_parser: RTL and testbench



---
 rtl/bno085_report_parser.sv | 198 +++++++++++++++++++
 tb/tb_bno085_report_parser.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bno085_report_parser.sv
// SHTP report parser for the BNO085: extracts quaternion and gyroscope words on channel 3.
// Optional macro BNO085_PARSER_ROTVEC_EN adds rotation vector (0x05) parsing as a quaternion source.
module bno085_report_parser (
  input  logic               clk,
  input  logic               rst,
  input  logic               pkt_start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  input  logic               pkt_end,
  output logic signed [15:0] quat_w,
  output logic signed [15:0] quat_x,
  output logic signed [15:0] quat_y,
  output logic signed [15:0] quat_z,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               quat_valid,
  output logic               gyro_valid,
  output logic               quat_upd,
  output logic               gyro_upd,
  output logic [7:0]         err_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_ID, S_BODY, S_DRAIN} state_t;
  typedef enum logic [1:0] {T_NONE, T_QUAT, T_GYRO} tgt_t;

  state_t             state, state_nxt;
  logic [1:0]         hcnt;
  logic [7:0]         len_lo;
  logic [6:0]         len_hi;
  logic [7:0]         chan;
  logic [14:0]        len, rem, rem_dec;
  logic [3:0]         idx, rlen;
  tgt_t               tgt;
  logic               start, err_evt, commit_q, commit_g, body_last, sh_we;
  logic               id_known;
  logic [3:0]         id_len;
  tgt_t               id_tgt;
  logic [1:0]         widx;
  logic signed [15:0] sh [4];
  logic signed [15:0] sh_cur [4];

  assign start     = byte_valid & pkt_start;
  assign len       = {len_hi, len_lo};
  assign rem_dec   = rem - 15'd1;
  assign body_last = byte_valid && (idx == rlen - 4'd1);
  assign sh_we     = (state == S_BODY) && byte_valid && !start && (idx >= 4'd4) && (idx <= 4'd11);
  // idx 4..11 maps to word 0..3; idx[2:1] + 2 wraps 2,3,0,1 onto 0,1,2,3
  assign widx      = idx[2:1] + 2'd2;

  always_comb begin
    id_known = 1'b1;
    id_len   = 4'd0;
    id_tgt   = T_NONE;
    case (byte_data)
      8'h08: begin id_len = 4'd12; id_tgt = T_QUAT; end
`ifdef BNO085_PARSER_ROTVEC_EN
      8'h05: begin id_len = 4'd14; id_tgt = T_QUAT; end
`endif
      8'h02: begin id_len = 4'd10; id_tgt = T_GYRO; end
      8'hFB, 8'hFA: id_len = 4'd5;
      default: id_known = 1'b0;
    endcase
  end

  // Shadow view including the byte being accepted, so the final byte commits in the same edge
  always_comb begin
    for (int i = 0; i < 4; i++) sh_cur[i] = sh[i];
    if (sh_we) begin
      if (idx[0]) sh_cur[widx][15:8] = byte_data;
      else        sh_cur[widx][7:0]  = byte_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_evt   = 1'b0;
    commit_q  = 1'b0;
    commit_g  = 1'b0;
    if (start) begin
      if (state == S_BODY) err_evt = 1'b1;
      state_nxt = S_HDR;
    end else begin
      case (state)
        S_HDR: begin
          if (byte_valid && hcnt == 2'd3)
            state_nxt = (chan == 8'd3 && len > 15'd4) ? S_ID : S_DRAIN;
        end
        S_ID: begin
          if (byte_valid) begin
            if (!id_known || rem_dec == 15'd0) begin
              err_evt   = 1'b1;
              state_nxt = S_DRAIN;
            end else begin
              state_nxt = S_BODY;
            end
          end
        end
        S_BODY: begin
          if (body_last) begin
            commit_q  = (tgt == T_QUAT);
            commit_g  = (tgt == T_GYRO);
            state_nxt = (rem_dec == 15'd0) ? S_DRAIN : S_ID;
          end else if (byte_valid && rem_dec == 15'd0) begin
            err_evt   = 1'b1;
            state_nxt = S_DRAIN;
          end
        end
        default: ;
      endcase
      if (pkt_end) begin
        if (state == S_BODY && !body_last) err_evt = 1'b1;
        state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= 2'd0;
      rem  <= 15'd0;
      idx  <= 4'd0;
      rlen <= 4'd0;
      tgt  <= T_NONE;
    end else begin
      if (start)
        hcnt <= 2'd1;
      else if (state == S_HDR && byte_valid)
        hcnt <= hcnt + 2'd1;
      if (!start && byte_valid) begin
        if (state == S_HDR && hcnt == 2'd3)
          rem <= len - 15'd4;
        else if (state == S_ID || state == S_BODY)
          rem <= rem_dec;
        if (state == S_ID) begin
          idx  <= 4'd1;
          rlen <= id_len;
          tgt  <= id_tgt;
        end else if (state == S_BODY) begin
          idx <= idx + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start)
      len_lo <= byte_data;
    else if (state == S_HDR && byte_valid) begin
      if (hcnt == 2'd1) len_hi <= byte_data[6:0];
      if (hcnt == 2'd2) chan   <= byte_data;
    end
    if (sh_we)
      for (int i = 0; i < 4; i++) sh[i] <= sh_cur[i];
  end

  // Committed outputs: whole vectors update together on the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quat_w     <= '0;
      quat_x     <= '0;
      quat_y     <= '0;
      quat_z     <= '0;
      gyro_x     <= '0;
      gyro_y     <= '0;
      gyro_z     <= '0;
      quat_valid <= 1'b0;
      gyro_valid <= 1'b0;
      quat_upd   <= 1'b0;
      gyro_upd   <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      quat_upd <= commit_q;
      gyro_upd <= commit_g;
      if (commit_q) begin
        quat_x     <= sh_cur[0];
        quat_y     <= sh_cur[1];
        quat_z     <= sh_cur[2];
        quat_w     <= sh_cur[3];
        quat_valid <= 1'b1;
      end
      if (commit_g) begin
        gyro_x     <= sh_cur[0];
        gyro_y     <= sh_cur[1];
        gyro_z     <= sh_cur[2];
        gyro_valid <= 1'b1;
      end
      if (err_evt && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bno085_report_parser.sv
// Directed bench for bno085_report_parser with a commit scoreboard.
module tb_bno085_report_parser;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pkt_start = 1'b0;
  logic               byte_valid = 1'b0;
  logic [7:0]         byte_data = 8'h00;
  logic               pkt_end = 1'b0;
  logic signed [15:0] quat_w, quat_x, quat_y, quat_z;
  logic signed [15:0] gyro_x, gyro_y, gyro_z;
  logic               quat_valid, gyro_valid, quat_upd, gyro_upd;
  logic [7:0]         err_cnt;

  bno085_report_parser dut (
    .clk(clk), .rst(rst), .pkt_start(pkt_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .pkt_end(pkt_end),
    .quat_w(quat_w), .quat_x(quat_x), .quat_y(quat_y), .quat_z(quat_z),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .quat_valid(quat_valid), .gyro_valid(gyro_valid),
    .quat_upd(quat_upd), .gyro_upd(gyro_upd), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        g;
    logic [15:0] x, y, z, w;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         nq = 0, ng = 0, exp_nq = 0, exp_ng = 0;
  int         exp_err = 0;
  logic [7:0] pk[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic push(input logic g, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] z, input logic [15:0] w);
    exp_t e;
    e.g = g; e.x = x; e.y = y; e.z = z; e.w = w;
    exp_q.push_back(e);
    if (g) exp_ng++; else exp_nq++;
  endtask

  task automatic send_pk(input bit end_last);
    for (int i = 0; i < pk.size(); i++) begin
      pkt_start  = (i == 0);
      byte_valid = 1'b1;
      byte_data  = pk[i];
      pkt_end    = end_last && (i == pk.size() - 1);
      @(posedge clk); #1;
    end
    pkt_start = 1'b0; byte_valid = 1'b0; pkt_end = 1'b0;
  endtask

  task automatic pend();
    pkt_end = 1'b1;
    @(posedge clk); #1;
    pkt_end = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: each commit pulse pops and checks the oldest expected vector
  always @(negedge clk) begin
    if (!rst && (quat_upd || gyro_upd)) begin
      exp_t e;
      if (quat_upd) nq++;
      if (gyro_upd) ng++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL upd_unexpected observed quat_upd=%0b gyro_upd=%0b expected none", quat_upd, gyro_upd);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("upd_kind", {15'd0, gyro_upd}, {15'd0, e.g});
        if (e.g) begin
          chk("gyro_x", gyro_x, e.x);
          chk("gyro_y", gyro_y, e.y);
          chk("gyro_z", gyro_z, e.z);
        end else begin
          chk("quat_x", quat_x, e.x);
          chk("quat_y", quat_y, e.y);
          chk("quat_z", quat_z, e.z);
          chk("quat_w", quat_w, e.w);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_quat_w", quat_w, 16'h0);
    chk("rst_gyro_z", gyro_z, 16'h0);
    chk("rst_valid", {14'd0, quat_valid, gyro_valid}, 16'h0);
    chk("rst_upd", {14'd0, quat_upd, gyro_upd}, 16'h0);
    chk("rst_err", {8'd0, err_cnt}, 16'h0);
    rst = 1'b0;
    gap(2);

    // Game rotation behind a skipped 0xFB report
    push(1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h2000);
    pk = '{8'h15, 8'h00, 8'h03, 8'h07, 8'hFB, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h08, 8'h01, 8'h03, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20};
    send_pk(1'b0);
    pend();
    gap(2);
    chk("grv_quat_valid", {15'd0, quat_valid}, 16'h1);
    chk("grv_err", {8'd0, err_cnt}, 16'h0);
    chk("grv_upd_count", 16'(nq), 16'(exp_nq));

    // Wrong channel
    pk = '{8'h0E, 8'h00, 8'h02, 8'h00, 8'h02, 8'h05, 8'h03, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
    send_pk(1'b1);
    gap(2);
    chk("wch_gyro_valid", {15'd0, gyro_valid}, 16'h0);
    chk("wch_gyro_x", gyro_x, 16'h0);
    chk("wch_err", {8'd0, err_cnt}, 16'h0);

    // Gyro, back-to-back with pkt_end on the last byte
    push(1'b1, 16'h1234, 16'hFFCC, 16'h8000, 16'h0);
    pk = '{8'h0E, 8'h00, 8'h03, 8'h01, 8'h02, 8'h05, 8'h03, 8'h00, 8'h34, 8'h12, 8'hCC, 8'hFF, 8'h00, 8'h80};
    send_pk(1'b1);
    gap(2);
    chk("gyr_gyro_valid", {15'd0, gyro_valid}, 16'h1);
    chk("gyr_upd_count", 16'(ng), 16'(exp_ng));
    chk("gyr_err", {8'd0, err_cnt}, 16'h0);

    // Truncation by pkt_end after k=7, then a complete packet
    pk = '{8'h15, 8'h00, 8'h03, 8'h07, 8'hFB, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h08, 8'h01, 8'h03, 8'h00, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    send_pk(1'b0);
    pend();
    exp_err++;
    gap(2);
    chk("trn_err", {8'd0, err_cnt}, 16'(exp_err));
    chk("trn_quat_x_held", quat_x, 16'h4000);
    push(1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    pk = '{8'h15, 8'h00, 8'h03, 8'h08, 8'hFB, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h08, 8'h02, 8'h03, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
    send_pk(1'b1);
    gap(2);

    // Unknown ID, then pkt_start while in BODY
    pk = '{8'h08, 8'h00, 8'h03, 8'h00, 8'h77, 8'h00, 8'h00, 8'h00};
    send_pk(1'b0);
    pend();
    exp_err++;
    gap(1);
    chk("unk_err", {8'd0, err_cnt}, 16'(exp_err));
    pk = '{8'h0E, 8'h00, 8'h03, 8'h00, 8'h02, 8'h05, 8'h03, 8'h00, 8'h34};
    send_pk(1'b0);
    exp_err++;
    push(1'b1, 16'h3456, 16'h0001, 16'h7FFF, 16'h0);
    pk = '{8'h0E, 8'h00, 8'h03, 8'h02, 8'h02, 8'h05, 8'h03, 8'h00, 8'h56, 8'h34, 8'h01, 8'h00, 8'hFF, 8'h7F};
    send_pk(1'b1);
    gap(2);
    chk("abt_err", {8'd0, err_cnt}, 16'(exp_err));

    // Packet length shorter than the report
    pk = '{8'h0A, 8'h00, 8'h03, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h99, 8'h99};
    send_pk(1'b0);
    exp_err++;
    pend();
    gap(2);
    chk("len_err", {8'd0, err_cnt}, 16'(exp_err));
    chk("len_quat_x_held", quat_x, 16'h1111);

    // Two reports in one packet, continuation bit set in the length
    push(1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0);
    push(1'b0, 16'h000A, 16'h000B, 16'h000C, 16'h000D);
    pk = '{8'h1A, 8'h80, 8'h03, 8'h05,
           8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00,
           8'h08, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h0B, 8'h00, 8'h0C, 8'h00, 8'h0D, 8'h00};
    send_pk(1'b1);
    gap(2);
    chk("mul_err", {8'd0, err_cnt}, 16'(exp_err));

    // Rotation vector 0x05
`ifdef BNO085_PARSER_ROTVEC_EN
    push(1'b0, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
`else
    exp_err++;
`endif
    pk = '{8'h12, 8'h00, 8'h03, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pk(1'b1);
    gap(2);
    chk("rv_err", {8'd0, err_cnt}, 16'(exp_err));
`ifdef BNO085_PARSER_ROTVEC_EN
    chk("rv_quat_x", quat_x, 16'h0100);
`else
    chk("rv_quat_x_held", quat_x, 16'h000A);
`endif

    // Error counter saturation
    pk = '{8'h05, 8'h00, 8'h03, 8'h00, 8'h77};
    for (int i = 0; i < 260; i++) send_pk(1'b1);
    gap(2);
    chk("sat_err", {8'd0, err_cnt}, 16'h00FF);
    chk("upd_count_q", 16'(nq), 16'(exp_nq));
    chk("upd_count_g", 16'(ng), 16'(exp_ng));
    chk("sb_empty", 16'(exp_q.size()), 16'h0);

    // Reset in the middle of a report
    pk = '{8'h0E, 8'h00, 8'h03, 8'h00, 8'h02, 8'h05, 8'h03, 8'h00, 8'h34, 8'h12};
    send_pk(1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_gyro_x", gyro_x, 16'h0);
    chk("mrst_quat_w", quat_w, 16'h0);
    chk("mrst_valid", {14'd0, quat_valid, gyro_valid}, 16'h0);
    chk("mrst_err", {8'd0, err_cnt}, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    gap(1);
    push(1'b1, 16'hFFFF, 16'h0080, 16'h7F00, 16'h0);
    pk = '{8'h0E, 8'h00, 8'h03, 8'h00, 8'h02, 8'h05, 8'h03, 8'h00, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h7F};
    send_pk(1'b1);
    gap(3);
    chk("post_gyro_valid", {15'd0, gyro_valid}, 16'h1);
    chk("post_err", {8'd0, err_cnt}, 16'h0);
    chk("final_sb_empty", 16'(exp_q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
